// File: rtl/sid_mix_if.sv
// sid_mix_if: register bus for the SID voice mixer.
//   cs   - register select
//   we   - write enable (qualified by cs)
//   a    - register address
//   di   - write data
//   dout - registered read data (one-cycle latency)
// The read data is named dout because "do" is a SystemVerilog keyword.
interface sid_mix_if #(
  parameter int unsigned ADDR_W = 3
);
  logic              cs;
  logic              we;
  logic [ADDR_W-1:0] a;
  logic [7:0]        di;
  logic [7:0]        dout;

  modport master (output cs, output we, output a, output di, input dout);
  modport slave  (input cs, input we, input a, input di, output dout);
endinterface

// File: rtl/sid_mix.sv
// sid_mix: time-multiplexed SID voice mixer.
// Each frame, one shared multiplier forms the wave*envelope products of all
// voices. The products are summed into a filter-bound bus and a direct bus.
// The filter return is merged in and master volume is applied.
// Ports:
//   clk, reset_n    - clock, asynchronous active-low reset
//   tick            - start-of-frame strobe
//   wave, env       - packed per-voice wave / envelope inputs (unsigned)
//   flt_out         - filter return, sampled in the final frame cycle
//   bus             - register bus (per-voice route/mute, volume, status)
//   flt_in, audio   - frame results, held between frames
//   valid           - one-cycle pulse when audio updates
//   busy, overrun   - frame in progress, sticky dropped-tick flag
// Build option: define SID_MIX_SAT_EN for a fixed 4-voice-headroom audio
// window with clamping; the default window uses full headroom.
module sid_mix #(
  parameter int unsigned VOICES = 3,
  parameter int unsigned WAVE_W = 12,
  parameter int unsigned ENV_W  = 8,
  parameter int unsigned ADDR_W = $clog2(VOICES + 2)
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     tick,
  input  logic [VOICES*WAVE_W-1:0] wave,
  input  logic [VOICES*ENV_W-1:0]  env,
  input  logic [WAVE_W-1:0]        flt_out,
  sid_mix_if.slave                 bus,
  output logic [WAVE_W-1:0]        flt_in,
  output logic [WAVE_W-1:0]        audio,
  output logic                     valid,
  output logic                     busy,
  output logic                     overrun
);
  localparam int unsigned SUM_W  = WAVE_W + ENV_W + $clog2(VOICES + 1);
  localparam int unsigned PROD_W = WAVE_W + ENV_W;
  localparam int unsigned IDX_W  = (VOICES > 1) ? $clog2(VOICES) : 1;
  localparam int unsigned WIN_W  = WAVE_W - 4;
`ifdef SID_MIX_SAT_EN
  localparam int unsigned WIN_HI = WAVE_W + ENV_W + 1;
  localparam int unsigned MIX_W  = (SUM_W > WIN_HI + 1) ? SUM_W : WIN_HI + 1;
`else
  localparam int unsigned WIN_HI = SUM_W - 1;
  localparam int unsigned MIX_W  = SUM_W;
`endif
  localparam int unsigned WIN_LO = WIN_HI + 1 - WIN_W;

  typedef enum logic [1:0] {S_IDLE, S_ACCUM, S_DRAIN, S_FINAL} state_e;

  state_e             state_q, state_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [SUM_W-1:0]   fsum_q, fsum_d, dsum_q, dsum_d;
  logic [PROD_W-1:0]  prod_q, prod_d;
  logic               prod_flt_q, prod_flt_d, prod_mute_q, prod_mute_d;
  logic               prod_vld_q, prod_vld_d;
  logic [7:0]         ctrl_q [VOICES];
  logic [7:0]         ctrl_d [VOICES];
  logic [7:0]         vol_q, vol_d, dout_q, dout_d;
  logic [WAVE_W-1:0]  flt_in_q, flt_in_d, audio_q, audio_d;
  logic               valid_q, valid_d, busy_q, busy_d, overrun_q, overrun_d;

  logic [WAVE_W-1:0]  wave_c;
  logic [ENV_W-1:0]   env_c;
  logic               route_c, mute_c, clr_c;
  logic [MIX_W-1:0]   mix_c;
  logic [WIN_W-1:0]   win_c;

  // State and datapath registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= S_IDLE;
      idx_q       <= '0;
      fsum_q      <= '0;
      dsum_q      <= '0;
      prod_q      <= '0;
      prod_flt_q  <= 1'b0;
      prod_mute_q <= 1'b0;
      prod_vld_q  <= 1'b0;
      ctrl_q      <= '{default: '0};
      vol_q       <= '0;
      dout_q      <= '0;
      flt_in_q    <= '0;
      audio_q     <= '0;
      valid_q     <= 1'b0;
      busy_q      <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      fsum_q      <= fsum_d;
      dsum_q      <= dsum_d;
      prod_q      <= prod_d;
      prod_flt_q  <= prod_flt_d;
      prod_mute_q <= prod_mute_d;
      prod_vld_q  <= prod_vld_d;
      ctrl_q      <= ctrl_d;
      vol_q       <= vol_d;
      dout_q      <= dout_d;
      flt_in_q    <= flt_in_d;
      audio_q     <= audio_d;
      valid_q     <= valid_d;
      busy_q      <= busy_d;
      overrun_q   <= overrun_d;
    end
  end

  // Next-state, register bank and datapath
  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    fsum_d      = fsum_q;
    dsum_d      = dsum_q;
    prod_d      = prod_q;
    prod_flt_d  = prod_flt_q;
    prod_mute_d = prod_mute_q;
    prod_vld_d  = prod_vld_q;
    ctrl_d      = ctrl_q;
    vol_d       = vol_q;
    dout_d      = '0;
    flt_in_d    = flt_in_q;
    audio_d     = audio_q;
    valid_d     = 1'b0;
    wave_c      = '0;
    env_c       = '0;
    route_c     = 1'b0;
    mute_c      = 1'b0;
    mix_c       = '0;
    win_c       = '0;
    clr_c       = 1'b0;

    // Register writes and reads
    if (bus.cs && bus.we) begin
      for (int i = 0; i < VOICES; i++)
        if (bus.a == ADDR_W'(i)) ctrl_d[i] = bus.di;
      if (bus.a == ADDR_W'(VOICES)) vol_d = bus.di;
      clr_c = (bus.a == ADDR_W'(VOICES + 1)) && bus.di[0];
    end else if (bus.cs) begin
      for (int i = 0; i < VOICES; i++)
        if (bus.a == ADDR_W'(i)) dout_d = ctrl_q[i];
      if (bus.a == ADDR_W'(VOICES)) dout_d = vol_q;
      if (bus.a == ADDR_W'(VOICES + 1)) dout_d = {7'b0, overrun_q};
    end

    // A dropped tick wins over a same-cycle clear
    overrun_d = (tick && (state_q != S_IDLE)) || (overrun_q && !clr_c);

    // Voice selected by idx, with its routing as currently stored
    for (int i = 0; i < VOICES; i++) begin
      if (idx_q == IDX_W'(i)) begin
        wave_c  = wave[i*WAVE_W +: WAVE_W];
        env_c   = env[i*ENV_W +: ENV_W];
        route_c = ctrl_q[i][0];
        mute_c  = ctrl_q[i][1];
      end
    end

    // Fold the previously issued product into its bus
    if ((state_q == S_ACCUM || state_q == S_DRAIN) && prod_vld_q) begin
      if (prod_flt_q)        fsum_d = fsum_q + SUM_W'(prod_q);
      else if (!prod_mute_q) dsum_d = dsum_q + SUM_W'(prod_q);
    end

    case (state_q)
      S_IDLE: begin
        if (tick) begin
          state_d    = S_ACCUM;
          idx_d      = '0;
          fsum_d     = '0;
          dsum_d     = '0;
          prod_vld_d = 1'b0;
        end
      end
      S_ACCUM: begin
        prod_d      = PROD_W'(wave_c) * PROD_W'(env_c);
        prod_flt_d  = route_c;
        prod_mute_d = mute_c;
        prod_vld_d  = 1'b1;
        if (idx_q == IDX_W'(VOICES - 1)) state_d = S_DRAIN;
        else                             idx_d   = idx_q + IDX_W'(1);
      end
      S_DRAIN: begin
        prod_vld_d = 1'b0;
        state_d    = S_FINAL;
      end
      S_FINAL: begin
        flt_in_d = WAVE_W'(fsum_q >> (SUM_W - WAVE_W));
        mix_c    = MIX_W'(dsum_q) + MIX_W'({flt_out, {ENV_W{1'b0}}});
        win_c    = WIN_W'(mix_c >> WIN_LO);
`ifdef SID_MIX_SAT_EN
        if ((mix_c >> (WIN_HI + 1)) != '0) win_c = '1;
`endif
        audio_d  = WAVE_W'(vol_q[3:0]) * WAVE_W'(win_c);
        valid_d  = 1'b1;
        state_d  = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    busy_d = (state_d != S_IDLE);
  end

  assign bus.dout = dout_q;
  assign flt_in   = flt_in_q;
  assign audio    = audio_q;
  assign valid    = valid_q;
  assign busy     = busy_q;
  assign overrun  = overrun_q;
endmodule
